// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the FSM state encoding and the mm:ss field width and limit.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } timer_state_t;

    localparam int MAX_MMSS = 59;
    localparam int TIME_W   = 6;

endpackage

// File: rtl/mmss_counter.sv
// Minutes/seconds register pair with modulo-60 increments and borrow-aware
// decrement; clr has priority over every other control.
module mmss_counter
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc_min,
    input  logic              inc_sec,
    input  logic              dec,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              zero
);

    localparam logic [TIME_W-1:0] MAX  = TIME_W'(MAX_MMSS);
    localparam logic [TIME_W-1:0] ONE  = TIME_W'(1);
    localparam logic [TIME_W-1:0] NONE = '0;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            minutes <= NONE;
            seconds <= NONE;
        end else if (dec) begin
            if (seconds != NONE) begin
                seconds <= seconds - ONE;
            end else if (minutes != NONE) begin
                minutes <= minutes - ONE;
                seconds <= MAX;
            end
        end else begin
            // Seconds wrap without carrying into minutes.
            if (inc_min) begin
                minutes <= (minutes >= MAX) ? NONE : minutes + ONE;
            end
            if (inc_sec) begin
                seconds <= (seconds >= MAX) ? NONE : seconds + ONE;
            end
        end
    end

    assign zero = (minutes == NONE) && (seconds == NONE);

endmodule

// File: rtl/countdown_timer.sv
// Kitchen-style mm:ss countdown timer: IDLE/RUN/PAUSE/EXPIRED FSM driving an
// mmss_counter, with a timed alarm phase and registered status flags.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              btn_start,
    input  logic              btn_clear,
    input  logic              btn_min_inc,
    input  logic              btn_sec_inc,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              blink,
    output logic              alarm,
    output logic              running
);

    localparam int CNT_W = $clog2(ALARM_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    timer_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clr, inc_min, inc_sec, dec;
    logic             zero, last;

    mmss_counter u_mmss (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .inc_min (inc_min),
        .inc_sec (inc_sec),
        .dec     (dec),
        .minutes (minutes),
        .seconds (seconds),
        .zero    (zero)
    );

    // The tick that lands on 00:00 is the one taken at 00:01.
    assign last = (minutes == '0) && (seconds == TIME_W'(1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr       = 1'b0;
        inc_min   = 1'b0;
        inc_sec   = 1'b0;
        dec       = 1'b0;
        if (btn_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            clr       = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_start) begin
                        if (!zero) state_nxt = RUN;
                    end else begin
                        inc_min = btn_min_inc;
                        inc_sec = btn_sec_inc;
                    end
                end
                RUN: begin
                    if (btn_start) begin
                        state_nxt = PAUSE;
                    end else if (tick_1hz) begin
                        dec = 1'b1;
                        if (last) begin
                            state_nxt = EXPIRED;
                            cnt_nxt   = '0;
                        end
                    end
                end
                PAUSE: begin
                    if (btn_start) state_nxt = RUN;
                end
                EXPIRED: begin
                    if (btn_start) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (tick_1hz) begin
                        if (cnt >= CNT_LAST) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Flags are registered from the next state so they align with the time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            blink   <= 1'b0;
            alarm   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            blink   <= (state_nxt == PAUSE) || (state_nxt == EXPIRED);
            alarm   <= (state_nxt == EXPIRED);
            running <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes expected flags and
// time into a queue, a negedge monitor pops and compares each entry.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_min_inc = 1'b0;
    logic       btn_sec_inc = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blink;
    logic       alarm;
    logic       running;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_CLR  = 5'b10000;
    localparam logic [4:0] P_ST   = 5'b01000;
    localparam logic [4:0] P_TK   = 5'b00100;
    localparam logic [4:0] P_MI   = 5'b00010;
    localparam logic [4:0] P_SI   = 5'b00001;

    countdown_timer #(.ALARM_TICKS(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .btn_start   (btn_start),
        .btn_clear   (btn_clear),
        .btn_min_inc (btn_min_inc),
        .btn_sec_inc (btn_sec_inc),
        .minutes     (minutes),
        .seconds     (seconds),
        .blink       (blink),
        .alarm       (alarm),
        .running     (running)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ex(input logic r, input logic b,
                                       input logic a, input int m,
                                       input int s);
        return {r, b, a, 6'(m), 6'(s)};
    endfunction

    // One clock: drive pulses at negedge, push expectation after posedge.
    task automatic step(input logic [4:0] p, input bit chk,
                        input string name, input logic [14:0] e);
        @(negedge clk);
        {btn_clear, btn_start, tick_1hz, btn_min_inc, btn_sec_inc} = p;
        @(posedge clk);
        if (chk) sb.push_back('{name, e});
        @(negedge clk);
        {btn_clear, btn_start, tick_1hz, btn_min_inc, btn_sec_inc} = P_NONE;
    endtask

    task automatic go(input logic [4:0] p);
        step(p, 1'b0, "", '0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            logic [14:0] got;
            e = sb.pop_front();
            got = {running, blink, alarm, minutes, seconds};
            n_tests++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got r=%0b b=%0b a=%0b %0d:%0d, want r=%0b b=%0b a=%0b %0d:%0d",
                         e.name, got[14], got[13], got[12], got[11:6], got[5:0],
                         e.exp[14], e.exp[13], e.exp[12], e.exp[11:6], e.exp[5:0]);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(P_NONE, 1'b1, "reset", ex(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Seconds wrap without carry; minutes wrap 59 -> 0.
        for (int i = 1; i <= 60; i++) begin
            step(P_SI, (i == 59 || i == 60), "sec_inc", ex(0, 0, 0, 0, i % 60));
        end
        for (int i = 1; i <= 61; i++) begin
            step(P_MI, (i == 59 || i == 60 || i == 61), "min_inc",
                 ex(0, 0, 0, i % 60, 0));
        end
        step(P_NONE, 1'b1, "set_0100", ex(0, 0, 0, 1, 0));
        step(P_CLR, 1'b1, "clear", ex(0, 0, 0, 0, 0));
        step(P_MI | P_SI, 1'b1, "both_inc", ex(0, 0, 0, 1, 1));
        step(P_CLR, 1'b1, "clear2", ex(0, 0, 0, 0, 0));
        step(P_ST, 1'b1, "start_zero", ex(0, 0, 0, 0, 0));
        step(P_SI, 1'b1, "inc_after_zstart", ex(0, 0, 0, 0, 1));

        // 01:00 countdown to expiry.
        go(P_CLR);
        go(P_MI);
        step(P_ST, 1'b1, "run_0100", ex(1, 0, 0, 1, 0));
        step(P_TK, 1'b1, "tick_0059", ex(1, 0, 0, 0, 59));
        step(P_MI, 1'b1, "inc_ignored_run", ex(1, 0, 0, 0, 59));
        for (int s = 58; s >= 1; s--) begin
            step(P_TK, (s == 58 || s == 30 || s == 1), "countdown",
                 ex(1, 0, 0, 0, s));
        end
        step(P_TK, 1'b1, "expired", ex(0, 1, 1, 0, 0));
        step(P_SI, 1'b1, "inc_ignored_exp", ex(0, 1, 1, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            step(P_TK, (i == 9), "alarm_hold", ex(0, 1, 1, 0, 0));
        end
        step(P_TK, 1'b1, "alarm_done", ex(0, 0, 0, 0, 0));

        // Short run, then abort the alarm with start.
        go(P_SI);
        go(P_SI);
        go(P_ST);
        go(P_TK);
        step(P_TK, 1'b1, "expired2", ex(0, 1, 1, 0, 0));
        step(P_ST, 1'b1, "start_in_exp", ex(0, 0, 0, 0, 0));

        // Pause at 00:05 with a colliding tick.
        for (int i = 0; i < 5; i++) go(P_SI);
        step(P_ST, 1'b1, "run_0005", ex(1, 0, 0, 0, 5));
        step(P_ST | P_TK, 1'b1, "pause_drop_tick", ex(0, 1, 0, 0, 5));
        for (int i = 0; i < 3; i++) begin
            step(P_TK, 1'b1, "pause_hold", ex(0, 1, 0, 0, 5));
        end
        step(P_ST, 1'b1, "resume", ex(1, 0, 0, 0, 5));
        step(P_TK, 1'b1, "resume_tick", ex(1, 0, 0, 0, 4));
        go(P_ST);
        step(P_CLR | P_ST, 1'b1, "clear_beats_start", ex(0, 0, 0, 0, 0));

        // Reset mid-RUN at 01:30.
        go(P_MI);
        for (int i = 0; i < 30; i++) go(P_SI);
        step(P_ST, 1'b1, "run_0130", ex(1, 0, 0, 1, 30));
        rst_n = 1'b0;
        step(P_TK, 1'b1, "reset_mid_run", ex(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(P_SI, 1'b1, "first_after_reset", ex(0, 0, 0, 0, 1));

        // Reset mid-EXPIRED.
        go(P_ST);
        step(P_TK, 1'b1, "expired3", ex(0, 1, 1, 0, 0));
        rst_n = 1'b0;
        step(P_ST, 1'b1, "reset_mid_exp", ex(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
